// File: rtl/mult_rr_scheduler_if.sv
// rtl/mult_rr_scheduler_if.sv - request/response bundle for the shared round-robin multiplier
interface mult_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [2*W-1:0]    rsp_data;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin share of one WxW multiplier among NREQ requesters
// Optional: MULT_RR_SIGNED_EN selects a two's-complement multiply (default unsigned).
module mult_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_rr_scheduler_if.slave   bus,
  output logic                 busy
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] rsp_data_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_valid_q;
  logic           busy_q;

  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [2*W-1:0] product_d;
  int             cand;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  // Gated by rst so nothing is accepted while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && state_q == IDLE && grant_vld) bus.req_ready[grant_idx] = 1'b1;
  end

`ifdef MULT_RR_SIGNED_EN
  assign product_d = $signed({{W{a_q[W-1]}}, a_q}) * $signed({{W{b_q[W-1]}}, b_q});
`else
  assign product_d = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            a_q      <= bus.req_a[grant_idx*W +: W];
            b_q      <= bus.req_b[grant_idx*W +: W];
            id_q     <= grant_idx;
            rr_ptr_q <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            busy_q   <= 1'b1;
            state_q  <= MUL;
          end
        end
        MUL: begin
          rsp_data_q  <= product_d;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb/tb_mult_rr_scheduler.sv - table, directed and random checks of mult_rr_scheduler
module tb_mult_rr_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  mult_rr_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

  mult_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ref_ptr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ref_grant(input logic [NREQ-1:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    longint p;
`ifdef MULT_RR_SIGNED_EN
    p = longint'($signed(a)) * longint'($signed(b));
`else
    p = longint'(a) * longint'(b);
`endif
    return p[31:0];
  endfunction

  // Entered just after a negedge with the DUT idle and rsp_ready low; returns the same way.
  // hold = RESP cycles with rsp_ready low; 0 raises rsp_ready already during MUL.
  task automatic op(input logic [NREQ-1:0] mask, input int hold,
                    output logic [1:0] got_id, output logic [31:0] got_data);
    int g;
    logic [31:0] exp;
    logic [15:0] a, b;
    bus.req_valid = mask;
    #1;
    g = ref_grant(mask, ref_ptr);
    a = bus.req_a[g*W +: W];
    b = bus.req_b[g*W +: W];
    exp = ref_mul(a, b);
    check("idle_busy", busy, 0);
    check("idle_rsp_valid", bus.rsp_valid, 0);
    check("grant", bus.req_ready, 64'(1) << g);
    @(posedge clk);
    ref_ptr = (g + 1) % NREQ;
    @(negedge clk);
    if (hold == 0) bus.rsp_ready = 1'b1;
    #1;
    check("mul_rsp_valid", bus.rsp_valid, 0);
    check("mul_busy", busy, 1);
    check("mul_req_ready", bus.req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_data", bus.rsp_data, exp);
      check("bp_id", bus.rsp_id, g);
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_busy", busy, 1);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_data", bus.rsp_data, exp);
    check("rsp_id", bus.rsp_id, g);
    got_id   = bus.rsp_id;
    got_data = bus.rsp_data;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check("done_rsp_valid", bus.rsp_valid, 0);
    check("done_busy", busy, 0);
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] a;
    logic [15:0] b;
    int          hold;
    logic [1:0]  exp_id;
    logic [31:0] exp_u;
    logic [31:0] exp_s;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [1:0]  gid;
    logic [31:0] gdata;

    tbl[0] = '{4'b0100, 16'd300,  16'd7,    0, 2'd2, 32'd2100,     32'd2100};
    tbl[1] = '{4'b0001, 16'd0,    16'd1234, 0, 2'd0, 32'd0,        32'd0};
    tbl[2] = '{4'b1111, 16'hFFFF, 16'hFFFF, 0, 2'd1, 32'hFFFE0001, 32'h00000001};
    tbl[3] = '{4'b1001, 16'd1000, 16'd1000, 1, 2'd3, 32'd1000000,  32'd1000000};
    tbl[4] = '{4'b0010, 16'hFFFF, 16'd5,    5, 2'd1, 32'h0004FFFB, 32'hFFFFFFFB};
    tbl[5] = '{4'b0011, 16'd2,    16'd3,    2, 2'd0, 32'd6,        32'd6};

    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset held three cycles with every requester asking.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    rst = 1'b0;
    bus.req_valid = '1;
    #1;
    check("first_grant", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    ref_ptr = 0;

    for (int i = 0; i < 6; i++) begin
      bus.req_a = {NREQ{tbl[i].a}};
      bus.req_b = {NREQ{tbl[i].b}};
      op(tbl[i].mask, tbl[i].hold, gid, gdata);
      check($sformatf("tbl%0d_id", i), gid, tbl[i].exp_id);
`ifdef MULT_RR_SIGNED_EN
      check($sformatf("tbl%0d_data", i), gdata, tbl[i].exp_s);
`else
      check($sformatf("tbl%0d_data", i), gdata, tbl[i].exp_u);
`endif
    end

    // Asynchronous reset while the op sits in MUL: it must vanish.
    bus.req_a = {NREQ{16'd9}};
    bus.req_b = {NREQ{16'd9}};
    bus.req_valid = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    check("mulrst_rsp_valid", bus.rsp_valid, 0);
    check("mulrst_busy", busy, 0);
    check("mulrst_rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    rst = 1'b0;
    ref_ptr = 0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("mulrst_no_rsp", bus.rsp_valid, 0);
      check("mulrst_idle", busy, 0);
    end
    bus.rsp_ready = 1'b0;
    @(negedge clk);

    // Fairness: all asking, requester k multiplies (k+1)*10.
    for (int k = 0; k < NREQ; k++) begin
      bus.req_a[k*W +: W] = 16'(k + 1);
      bus.req_b[k*W +: W] = 16'd10;
    end
    for (int i = 0; i < 8; i++) begin
      op(4'b1111, i % 2, gid, gdata);
      check($sformatf("fair%0d_id", i), gid, i % NREQ);
      check($sformatf("fair%0d_data", i), gdata, ((i % NREQ) + 1) * 10);
    end

    for (int i = 0; i < 40; i++) begin
      bus.req_a = {$urandom, $urandom};
      bus.req_b = {$urandom, $urandom};
      if (i % 5 == 0) bus.req_a[15:0] = 16'hFFFF;
      op(4'($urandom_range(1, 15)), $urandom_range(0, 3), gid, gdata);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
